// File: rtl/dnn_result_argmax.sv
// ---------------------------------------------------------------------------
// dnn_result_argmax
//
// Result capture, readout and classification stage behind the inference
// engine. When the engine pulses in_valid, all NUM_CLASSES signed scores are
// snapshotted into a local bank. The bank is then scanned serially, one
// compare per cycle, to find the winning class. The winner is offered on a
// valid/ready handshake. Any captured score can also be read back through a
// registered random-access port.
//
// Parameters
//   NUM_CLASSES  number of scores captured and scanned (>= 2)
//   DATA_WIDTH   signed width of each score
//   IDX_WIDTH    class/readout index width (derived from NUM_CLASSES)
//
// Ports
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   clear        synchronous soft clear; takes priority over in_valid
//   in_valid     one-cycle pulse meaning in_data holds final scores
//   in_data      packed scores, class k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy         high while a scan is in progress
//   class_valid  winning class is available
//   class_ready  consumer accepts the class when class_valid && class_ready
//   class_idx    index of the winning class
//   class_score  score of the winning class
//   overrun      sticky flag: in_valid arrived while the stage could not accept it
//   rd_idx       readout select
//   rd_data      registered captured score for rd_idx (bank[0] if out of range)
//
// Optional feature (macro RUNNER_UP_EN)
//   When defined, adds second_idx/second_score, which hold the runner-up
//   class using the same strict-greater / lower-index-wins rule.
// ---------------------------------------------------------------------------
module dnn_result_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = $clog2(NUM_CLASSES)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clear,
    input  logic                              in_valid,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data,
    output logic                              busy,
    output logic                              class_valid,
    input  logic                              class_ready,
    output logic [IDX_WIDTH-1:0]              class_idx,
    output logic [DATA_WIDTH-1:0]             class_score,
    output logic                              overrun,
    input  logic [IDX_WIDTH-1:0]              rd_idx,
    output logic [DATA_WIDTH-1:0]             rd_data
`ifdef RUNNER_UP_EN
    ,
    output logic [IDX_WIDTH-1:0]              second_idx,
    output logic [DATA_WIDTH-1:0]             second_score
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

    state_t                        state_q,      state_d;
    logic signed [DATA_WIDTH-1:0]  bank_q [NUM_CLASSES];
    logic signed [DATA_WIDTH-1:0]  bank_d [NUM_CLASSES];
    logic [IDX_WIDTH-1:0]          cnt_q,        cnt_d;
    logic                          fetch_on_q,   fetch_on_d;
    logic signed [DATA_WIDTH-1:0]  cand_q,       cand_d;
    logic [IDX_WIDTH-1:0]          cand_idx_q,   cand_idx_d;
    logic                          cand_vld_q,   cand_vld_d;
    logic [IDX_WIDTH-1:0]          best_idx_q,   best_idx_d;
    logic signed [DATA_WIDTH-1:0]  best_score_q, best_score_d;
    logic                          overrun_q,    overrun_d;
    logic [DATA_WIDTH-1:0]         rd_data_q,    rd_data_d;
`ifdef RUNNER_UP_EN
    logic [IDX_WIDTH-1:0]          sec_idx_q,    sec_idx_d;
    logic signed [DATA_WIDTH-1:0]  sec_score_q,  sec_score_d;
    logic                          sec_vld_q,    sec_vld_d;
`endif

    logic handshake;
    logic accept;
    logic cand_gt_best;
`ifdef RUNNER_UP_EN
    logic cand_gt_sec;
`endif

    assign handshake    = (state_q == ST_DONE) && class_ready;
    // A new capture is taken when idle, or in DONE on the very cycle the
    // current result is consumed, so back-to-back inferences need no bubble.
    assign accept       = in_valid && ((state_q == ST_IDLE) || handshake);
    assign cand_gt_best = (cand_q > best_score_q);
`ifdef RUNNER_UP_EN
    assign cand_gt_sec  = (cand_q > sec_score_q);
`endif

    // The scan is a two-stage pipeline: one cycle fetches bank[cnt] into the
    // candidate register, the next compares it against the running best. This
    // keeps the wide bank mux and the signed comparator on separate paths, and
    // is why the result appears NUM_CLASSES cycles after capture.
    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        cnt_d        = cnt_q;
        fetch_on_d   = fetch_on_q;
        cand_d       = cand_q;
        cand_idx_d   = cand_idx_q;
        cand_vld_d   = cand_vld_q;
        best_idx_d   = best_idx_q;
        best_score_d = best_score_q;
        overrun_d    = overrun_q;
`ifdef RUNNER_UP_EN
        sec_idx_d    = sec_idx_q;
        sec_score_d  = sec_score_q;
        sec_vld_d    = sec_vld_q;
`endif

        if (clear) begin
            state_d      = ST_IDLE;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bank_d[k] = '0;
            end
            cnt_d        = '0;
            fetch_on_d   = 1'b0;
            cand_d       = '0;
            cand_idx_d   = '0;
            cand_vld_d   = 1'b0;
            best_idx_d   = '0;
            best_score_d = '0;
            overrun_d    = 1'b0;
`ifdef RUNNER_UP_EN
            sec_idx_d    = '0;
            sec_score_d  = '0;
            sec_vld_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (cand_vld_q) begin
                        // Strictly greater replaces; on a tie the earlier
                        // (lower) index is kept.
                        if (cand_gt_best) begin
                            best_idx_d   = cand_idx_q;
                            best_score_d = cand_q;
`ifdef RUNNER_UP_EN
                            sec_idx_d    = best_idx_q;
                            sec_score_d  = best_score_q;
                            sec_vld_d    = 1'b1;
`endif
                        end
`ifdef RUNNER_UP_EN
                        else if (!sec_vld_q || cand_gt_sec) begin
                            sec_idx_d    = cand_idx_q;
                            sec_score_d  = cand_q;
                            sec_vld_d    = 1'b1;
                        end
`endif
                        if (cand_idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end
                    end

                    if (fetch_on_q) begin
                        cand_d     = bank_q[cnt_q];
                        cand_idx_d = cnt_q;
                        cand_vld_d = 1'b1;
                        if (cnt_q == LAST_IDX) begin
                            fetch_on_d = 1'b0;
                        end else begin
                            cnt_d = cnt_q + IDX_WIDTH'(1);
                        end
                    end else begin
                        cand_vld_d = 1'b0;
                    end
                end

                ST_DONE: begin
                    if (handshake) begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = state_q;
                end
            endcase

            // Capture overrides whatever the case above decided: class 0 seeds
            // the running best and the fetch pipeline restarts at class 1.
            if (accept) begin
                state_d = ST_SCAN;
                for (int k = 0; k < NUM_CLASSES; k++) begin
                    bank_d[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
                end
                best_idx_d   = '0;
                best_score_d = in_data[0 +: DATA_WIDTH];
                cnt_d        = IDX_WIDTH'(1);
                fetch_on_d   = 1'b1;
                cand_vld_d   = 1'b0;
`ifdef RUNNER_UP_EN
                sec_idx_d    = '0;
                sec_score_d  = '0;
                sec_vld_d    = 1'b0;
`endif
            end else if (in_valid) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Out-of-range readout indices fall back to class 0. The index is widened
    // before the range test so the bound is correct even when NUM_CLASSES is
    // an exact power of two.
    always_comb begin
        rd_data_d = '0;
        if (!clear) begin
            if (32'(rd_idx) < NUM_CLASSES) begin
                rd_data_d = bank_q[rd_idx];
            end else begin
                rd_data_d = bank_q[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                bank_q[k] <= '0;
            end
            cnt_q        <= '0;
            fetch_on_q   <= 1'b0;
            cand_q       <= '0;
            cand_idx_q   <= '0;
            cand_vld_q   <= 1'b0;
            best_idx_q   <= '0;
            best_score_q <= '0;
            overrun_q    <= 1'b0;
            rd_data_q    <= '0;
`ifdef RUNNER_UP_EN
            sec_idx_q    <= '0;
            sec_score_q  <= '0;
            sec_vld_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            cnt_q        <= cnt_d;
            fetch_on_q   <= fetch_on_d;
            cand_q       <= cand_d;
            cand_idx_q   <= cand_idx_d;
            cand_vld_q   <= cand_vld_d;
            best_idx_q   <= best_idx_d;
            best_score_q <= best_score_d;
            overrun_q    <= overrun_d;
            rd_data_q    <= rd_data_d;
`ifdef RUNNER_UP_EN
            sec_idx_q    <= sec_idx_d;
            sec_score_q  <= sec_score_d;
            sec_vld_q    <= sec_vld_d;
`endif
        end
    end

    assign busy        = (state_q == ST_SCAN);
    assign class_valid = (state_q == ST_DONE);
    assign class_idx   = best_idx_q;
    assign class_score = best_score_q;
    assign overrun     = overrun_q;
    assign rd_data     = rd_data_q;
`ifdef RUNNER_UP_EN
    assign second_idx   = sec_idx_q;
    assign second_score = sec_score_q;
`endif

endmodule

// File: tb/tb_dnn_result_argmax.sv
// ---------------------------------------------------------------------------
// tb_dnn_result_argmax
//
// Directed self-checking bench for dnn_result_argmax (NUM_CLASSES=10,
// DATA_WIDTH=16). Each test loads a hand-chosen score vector, waits for the
// result and compares against hand-computed winners, latencies, readout
// values and flag states. With RUNNER_UP_EN defined the runner-up outputs
// are also checked.
// ---------------------------------------------------------------------------
module tb_dnn_result_argmax;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic           in_valid;
    logic [N*W-1:0] in_data;
    logic           busy;
    logic           class_valid;
    logic           class_ready;
    logic [IW-1:0]  class_idx;
    logic [W-1:0]   class_score;
    logic           overrun;
    logic [IW-1:0]  rd_idx;
    logic [W-1:0]   rd_data;
`ifdef RUNNER_UP_EN
    logic [IW-1:0]  second_idx;
    logic [W-1:0]   second_score;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] scores [N];
    logic [W-1:0] vec_a  [N];
    logic [W-1:0] vec_c  [N];

    dnn_result_argmax #(
        .NUM_CLASSES (N),
        .DATA_WIDTH  (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .busy         (busy),
        .class_valid  (class_valid),
        .class_ready  (class_ready),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .overrun      (overrun),
        .rd_idx       (rd_idx),
        .rd_data      (rd_data)
`ifdef RUNNER_UP_EN
        ,
        .second_idx   (second_idx),
        .second_score (second_score)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N*W-1:0] packScores();
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) begin
            v[k*W +: W] = scores[k];
        end
        return v;
    endfunction

    // Advance to 1ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        in_data  = packScores();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitValid(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (class_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checkOutput(tag, n, exp_cycles);
    endtask

    task automatic handshake();
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
    endtask

    task automatic checkResult(input string tag, input int idx, input logic [W-1:0] score);
        checkOutput({tag, "_idx"}, 32'(class_idx), idx);
        checkOutput({tag, "_score"}, 32'(class_score), 32'(score));
    endtask

`ifdef RUNNER_UP_EN
    task automatic checkSecond(input string tag, input int idx, input logic [W-1:0] score);
        checkOutput({tag, "_sidx"}, 32'(second_idx), idx);
        checkOutput({tag, "_sscore"}, 32'(second_score), 32'(score));
    endtask
`endif

    initial begin
        rst         = 1'b1;
        clear       = 1'b0;
        in_valid    = 1'b0;
        class_ready = 1'b0;
        in_data     = '0;
        rd_idx      = '0;

        vec_a = '{16'hFFFB, 16'd100, 16'd3, 16'hFFEC, 16'd50,
                  16'd99,   16'd0,   16'd1, 16'hFF9C, 16'd7};
        for (int k = 0; k < N; k++) begin
            vec_c[k] = 16'h8000;
        end
        vec_c[9] = 16'h8001;

        // Reset state
        #2;
        checkOutput("rst_busy",    32'(busy),        0);
        checkOutput("rst_valid",   32'(class_valid), 0);
        checkOutput("rst_overrun", 32'(overrun),     0);
        checkOutput("rst_idx",     32'(class_idx),   0);
        checkOutput("rst_score",   32'(class_score), 0);
        checkOutput("rst_rd",      32'(rd_data),     0);
        #1;
        rst = 1'b0;
        tick();

        // Test 1: basic argmax, latency, readout sweep
        $display("[TB] test 1: basic capture and scan");
        scores = vec_a;
        applyStimulus();
        checkOutput("t1_busy", 32'(busy), 1);
        waitValid("t1_latency", 10);
        checkResult("t1", 1, 16'd100);
`ifdef RUNNER_UP_EN
        checkSecond("t1", 5, 16'd99);
`endif
        checkOutput("t1_overrun", 32'(overrun), 0);
        for (int i = 0; i < 16; i++) begin
            logic [W-1:0] exp_rd;
            rd_idx = IW'(i);
            tick();
            if (i < N) exp_rd = scores[i];
            else       exp_rd = scores[0];
            checkOutput($sformatf("t1_rd%0d", i), 32'(rd_data), 32'(exp_rd));
        end
        checkOutput("t1_valid_hold", 32'(class_valid), 1);
        handshake();
        checkOutput("t1_valid_drop", 32'(class_valid), 0);
        checkOutput("t1_busy_drop",  32'(busy),        0);

        // Test 2a: all zero -> class 0
        $display("[TB] test 2: ties");
        for (int k = 0; k < N; k++) scores[k] = 16'h0000;
        applyStimulus();
        waitValid("t2a_latency", 10);
        checkResult("t2a", 0, 16'h0000);
`ifdef RUNNER_UP_EN
        checkSecond("t2a", 1, 16'h0000);
`endif
        handshake();

        // Test 2b: two maxima at 3 and 8 -> lower index wins
        for (int k = 0; k < N; k++) scores[k] = 16'(k * 10);
        scores[3] = 16'h7FFF;
        scores[8] = 16'h7FFF;
        applyStimulus();
        waitValid("t2b_latency", 10);
        checkResult("t2b", 3, 16'h7FFF);
`ifdef RUNNER_UP_EN
        checkSecond("t2b", 8, 16'h7FFF);
`endif
        handshake();

        // Test 3: all negative, signed compare
        $display("[TB] test 3: signed compare");
        scores = vec_c;
        applyStimulus();
        waitValid("t3_latency", 10);
        checkResult("t3", 9, 16'h8001);
`ifdef RUNNER_UP_EN
        checkSecond("t3", 0, 16'h8000);
`endif
        handshake();

        // Test 4: in_valid during SCAN is ignored and flags overrun
        $display("[TB] test 4: overrun during scan and clear");
        scores = vec_a;
        applyStimulus();
        tick();
        tick();
        tick();
        scores = vec_c;
        applyStimulus();
        checkOutput("t4_overrun", 32'(overrun), 1);
        checkOutput("t4_busy",    32'(busy),    1);
        waitValid("t4_latency", 6);
        checkResult("t4", 1, 16'd100);
        rd_idx = 4'd4;
        tick();
        checkOutput("t4_rd_bank_kept", 32'(rd_data), 32'(16'd50));
        checkOutput("t4_overrun_sticky", 32'(overrun), 1);
        clear    = 1'b1;
        in_valid = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checkOutput("t4_clr_valid",   32'(class_valid), 0);
        checkOutput("t4_clr_busy",    32'(busy),        0);
        checkOutput("t4_clr_overrun", 32'(overrun),     0);
        checkOutput("t4_clr_idx",     32'(class_idx),   0);
        checkOutput("t4_clr_score",   32'(class_score), 0);
        rd_idx = 4'd1;
        tick();
        checkOutput("t4_clr_rd", 32'(rd_data), 0);

        // Test 5: backpressure, then handshake with simultaneous capture
        $display("[TB] test 5: backpressure and back-to-back capture");
        scores = vec_a;
        applyStimulus();
        waitValid("t5_latency", 10);
        repeat (20) tick();
        checkOutput("t5_valid_held", 32'(class_valid), 1);
        checkResult("t5_held", 1, 16'd100);
        scores      = vec_c;
        in_data     = packScores();
        in_valid    = 1'b1;
        class_ready = 1'b1;
        tick();
        in_valid    = 1'b0;
        class_ready = 1'b0;
        checkOutput("t5_b2b_busy",    32'(busy),        1);
        checkOutput("t5_b2b_valid",   32'(class_valid), 0);
        checkOutput("t5_b2b_overrun", 32'(overrun),     0);
        waitValid("t5_b2b_latency", 10);
        checkResult("t5_b2b", 9, 16'h8001);
`ifdef RUNNER_UP_EN
        checkSecond("t5_b2b", 0, 16'h8000);
`endif
        // in_valid in DONE without handshake is dropped
        scores = vec_a;
        applyStimulus();
        checkOutput("t5_done_overrun", 32'(overrun),     1);
        checkOutput("t5_done_valid",   32'(class_valid), 1);
        checkResult("t5_done", 9, 16'h8001);
        handshake();

        // Test 6: async reset in the middle of a scan
        $display("[TB] test 6: reset mid-scan");
        scores = vec_a;
        applyStimulus();
        tick();
        tick();
        checkOutput("t6_busy_pre", 32'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_busy",    32'(busy),        0);
        checkOutput("t6_valid",   32'(class_valid), 0);
        checkOutput("t6_idx",     32'(class_idx),   0);
        checkOutput("t6_score",   32'(class_score), 0);
        checkOutput("t6_overrun", 32'(overrun),     0);
        checkOutput("t6_rd",      32'(rd_data),     0);
        #1;
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
